// File: rtl/moggysoc_top.sv
// MoggySoC board top: tick-driven 4-bit LED pattern engine with button controls and RGB status.
// Optional macro RGB_DIM_PWM_EN dims both RGB LEDs to a 1/8 duty cycle.
module moggysoc_top #(
  parameter int unsigned TICK_CYCLES = 12_500_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_125,
  input  logic [3:0] push_buttons,
  input  logic [1:0] switches,
  output logic [3:0] leds,
  output logic [2:0] rgb_led_ld4,
  output logic [2:0] rgb_led_ld5
);

  localparam int unsigned FastCycles = TICK_CYCLES / 4;
  localparam int unsigned CntW       = $clog2(TICK_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne  = 1;
  localparam logic [CntW-1:0] CntSlow = CntW'(TICK_CYCLES);
  localparam logic [CntW-1:0] CntFast = CntW'(FastCycles);

  typedef enum logic [1:0] {
    ModeUp     = 2'b00,
    ModeDown   = 2'b01,
    ModeRotate = 2'b10,
    ModeFreeze = 2'b11
  } mode_e;

  // {switches, push_buttons} through a plain shift-register synchronizer.
  logic [5:0] sync_q [SYNC_STAGES] = '{default: '0};
  logic [5:0] in_s;

  always_ff @(posedge clk_125) begin
    sync_q[0] <= {switches, push_buttons};
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_s = sync_q[SYNC_STAGES-1];

  logic  rst, step_btn, fast, pause;
  mode_e mode;

  assign rst      = in_s[0];
  assign step_btn = in_s[1];
  assign fast     = in_s[2];
  assign pause    = in_s[3];
  assign mode     = mode_e'(in_s[5:4]);

  logic [CntW-1:0] cnt_q       = '0;
  logic [3:0]      leds_q      = '0;
  logic            hb_q        = 1'b0;
  logic            wrap_q      = 1'b0;
  logic            step_prev_q = 1'b0;
  logic [2:0]      ld4_q       = '0;
  logic [2:0]      ld5_q       = '0;

  logic [CntW-1:0] cnt_d, period;
  logic [3:0]      leds_d;
  logic            hb_d, wrap_d, tick, step, update;
  logic [2:0]      colour;
  logic            rgb_on;

  assign period = fast ? CntFast : CntSlow;

  always_comb begin
    cnt_d  = cnt_q;
    tick   = 1'b0;
    step   = step_btn & ~step_prev_q;
    leds_d = leds_q;
    hb_d   = hb_q;
    wrap_d = wrap_q;

    // A count already past a shortened period restarts silently.
    if (!pause) begin
      if (cnt_q >= period) begin
        cnt_d = '0;
      end else if (cnt_q == period - CntOne) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end

    update = tick | step;

    if (update) begin
      hb_d   = ~hb_q;
      wrap_d = 1'b0;
      case (mode)
        ModeUp: begin
          leds_d = leds_q + 4'd1;
          wrap_d = (leds_q == 4'hF);
        end
        ModeDown: begin
          leds_d = leds_q - 4'd1;
          wrap_d = (leds_q == 4'h0);
        end
        ModeRotate: begin
          if (!$onehot(leds_q)) begin
            leds_d = 4'b0001;
          end else begin
            leds_d = {leds_q[2:0], leds_q[3]};
            wrap_d = leds_q[3];
          end
        end
        default: ;
      endcase
    end

    case (mode)
      ModeUp:     colour = 3'b010;
      ModeDown:   colour = 3'b001;
      ModeRotate: colour = 3'b100;
      default:    colour = 3'b110;
    endcase
  end

`ifdef RGB_DIM_PWM_EN
  logic [7:0] pwm_q = '0;

  always_ff @(posedge clk_125) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 8'd1;
    end
  end

  assign rgb_on = (pwm_q[7:5] == 3'b000);
`else
  assign rgb_on = 1'b1;
`endif

  always_ff @(posedge clk_125) begin
    ld4_q <= rgb_on ? colour : 3'b000;
    if (rst) begin
      cnt_q       <= '0;
      leds_q      <= '0;
      hb_q        <= 1'b0;
      wrap_q      <= 1'b0;
      step_prev_q <= 1'b0;
      ld5_q       <= rgb_on ? {pause, 2'b00} : 3'b000;
    end else begin
      cnt_q       <= cnt_d;
      leds_q      <= leds_d;
      hb_q        <= hb_d;
      wrap_q      <= wrap_d;
      step_prev_q <= step_btn;
      ld5_q       <= rgb_on ? {pause, hb_d, wrap_d} : 3'b000;
    end
  end

  assign leds        = leds_q;
  assign rgb_led_ld4 = ld4_q;
  assign rgb_led_ld5 = ld5_q;

endmodule

// File: tb/tb_moggysoc_top.sv
// Directed bench for moggysoc_top: expected LED updates are queued as stimulus is applied and
// popped each time the heartbeat shows the DUT performed an update.
module tb_moggysoc_top;

  localparam int unsigned TickCycles = 16;
  localparam int unsigned SyncStages = 2;

  logic       clk_125 = 1'b0;
  logic [3:0] push_buttons = '0;
  logic [1:0] switches = '0;
  logic [3:0] leds;
  logic [2:0] rgb_led_ld4;
  logic [2:0] rgb_led_ld5;

  moggysoc_top #(
    .TICK_CYCLES(TickCycles),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk_125     (clk_125),
    .push_buttons(push_buttons),
    .switches    (switches),
    .leds        (leds),
    .rgb_led_ld4 (rgb_led_ld4),
    .rgb_led_ld5 (rgb_led_ld5)
  );

  always #4 clk_125 = ~clk_125;

  int unsigned cyc = 0;
  always @(posedge clk_125) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] leds;
    logic       wrap;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk_125);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] l, input logic w);
    exp_t e;
    e.leds = l;
    e.wrap = w;
    sb.push_back(e);
  endtask

  // Waits for n updates (heartbeat toggles); period != 0 also checks spacing after the first.
  task automatic check_updates(input string tag, input int n, input int period);
    int unsigned last;
    bit          have_last;
    logic        hb_prev;
    int          waited;
    exp_t        e;
    have_last = 1'b0;
    last      = 0;
    for (int i = 0; i < n; i++) begin
      waited  = 0;
      hb_prev = rgb_led_ld5[1];
      while (rgb_led_ld5[1] === hb_prev && waited < 200) begin
        tick_n(1);
        waited++;
      end
      check({tag, "_update_seen"}, 32'(waited < 200), 32'd1);
      if (waited >= 200) return;
      check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_leds"}, 32'(leds), 32'(e.leds));
        check({tag, "_wrap"}, 32'(rgb_led_ld5[0]), 32'(e.wrap));
      end
      if (period != 0 && have_last) check({tag, "_interval"}, cyc - last, 32'(period));
      last      = cyc;
      have_last = 1'b1;
    end
  endtask

  logic hb_ref;
  int   n;

  initial begin
    #1;
    check("powerup_leds", 32'(leds), 32'h0);
    check("powerup_ld5", 32'(rgb_led_ld5), 32'h0);

    // Reset, then count up through a wrap.
    push_buttons[0] = 1'b1;
    tick_n(4);
    push_buttons[0] = 1'b0;
    tick_n(3);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_ld5", 32'(rgb_led_ld5), 32'h0);
    check("up_ld4", 32'(rgb_led_ld4), 32'b010);
    for (int v = 1; v <= 15; v++) push(4'(v), 1'b0);
    push(4'h0, 1'b1);
    push(4'h1, 1'b0);
    check_updates("up", 17, TickCycles);

    // Down mode from reset: first update wraps 0 -> F.
    switches        = 2'b01;
    push_buttons[0] = 1'b1;
    tick_n(4);
    push_buttons[0] = 1'b0;
    push(4'hF, 1'b1);
    push(4'hE, 1'b0);
    push(4'hD, 1'b0);
    push(4'hC, 1'b0);
    check_updates("down", 4, TickCycles);
    check("down_ld4", 32'(rgb_led_ld4), 32'b001);

    // Count to 5, then rotate: non-one-hot loads 0001.
    switches        = 2'b00;
    push_buttons[0] = 1'b1;
    tick_n(4);
    push_buttons[0] = 1'b0;
    for (int v = 1; v <= 5; v++) push(4'(v), 1'b0);
    check_updates("up5", 5, TickCycles);
    switches = 2'b10;
    push(4'b0001, 1'b0);
    push(4'b0010, 1'b0);
    push(4'b0100, 1'b0);
    push(4'b1000, 1'b0);
    push(4'b0001, 1'b1);
    push(4'b0010, 1'b0);
    check_updates("rot", 6, TickCycles);
    check("rot_ld4", 32'(rgb_led_ld4), 32'b100);

    // Pause with a single step in the middle.
    switches        = 2'b00;
    push_buttons[3] = 1'b1;
    tick_n(5);
    check("pause_ld5", 32'(rgb_led_ld5[2]), 32'd1);
    hb_ref = rgb_led_ld5[1];
    tick_n(40);
    check("pause_leds_hold", 32'(leds), 32'h2);
    check("pause_hb_hold", 32'(rgb_led_ld5[1]), 32'(hb_ref));
    push_buttons[1] = 1'b1;
    push(4'h3, 1'b0);
    check_updates("pause_step", 1, 0);
    push_buttons[1] = 1'b0;
    hb_ref = rgb_led_ld5[1];
    tick_n(50);
    check("pause_single_step", 32'(leds), 32'h3);
    check("pause_hb_once", 32'(rgb_led_ld5[1]), 32'(hb_ref));

    // Speed-up: ticks every TickCycles/4, then a step landing on a tick.
    push_buttons[3] = 1'b0;
    push_buttons[2] = 1'b1;
    for (int v = 4; v <= 8; v++) push(4'(v), 1'b0);
    check_updates("fast", 5, TickCycles / 4);
    check("unpause_ld5", 32'(rgb_led_ld5[2]), 32'd0);
    tick_n(1);
    push_buttons[1] = 1'b1;
    push(4'h9, 1'b0);
    push(4'hA, 1'b0);
    check_updates("coincide", 2, TickCycles / 4);
    push_buttons[1] = 1'b0;

    // Freeze: leds hold, heartbeat keeps toggling.
    push_buttons[2] = 1'b0;
    switches        = 2'b11;
    for (int v = 0; v < 5; v++) push(4'hA, 1'b0);
    check_updates("freeze", 5, TickCycles);
    check("freeze_ld4", 32'(rgb_led_ld4), 32'b110);

    // Reset mid-operation.
    switches = 2'b00;
    push(4'hB, 1'b0);
    push(4'hC, 1'b0);
    check_updates("pre_reset", 2, TickCycles);
    push_buttons[0] = 1'b1;
    tick_n(SyncStages);
    check("reset_latency_early", 32'(leds), 32'hC);
    tick_n(1);
    check("reset_latency_leds", 32'(leds), 32'h0);
    check("reset_latency_ld5", 32'(rgb_led_ld5[1:0]), 32'h0);
    tick_n(3);
    hb_ref          = rgb_led_ld5[1];
    n               = 0;
    push_buttons[0] = 1'b0;
    while (rgb_led_ld5[1] === hb_ref && n < 100) begin
      tick_n(1);
      n++;
    end
    check("first_tick_latency", 32'(n), 32'(SyncStages + TickCycles));
    check("first_tick_leds", 32'(leds), 32'h1);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
